// File: rtl/p_mem_ctrl_if.sv
// ============================================================================
// p_mem_ctrl_if : requester (IF / MEM) and byte-wide RAM bus bundle
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface p_mem_ctrl_if;
  logic        rdy_in;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_len;
  logic        mem_sext;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic [31:0] ram_a;
  logic        ram_wr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din;

  // Controller side
  modport slave (
    input  rdy_in, if_req, if_addr, mem_req, mem_we, mem_len, mem_sext,
           mem_addr, mem_wdata, ram_din,
    output if_done, if_data, mem_done, mem_rdata, ram_a, ram_wr, ram_dout
  );

  // Requester / RAM side
  modport master (
    output rdy_in, if_req, if_addr, mem_req, mem_we, mem_len, mem_sext,
           mem_addr, mem_wdata, ram_din,
    input  if_done, if_data, mem_done, mem_rdata, ram_a, ram_wr, ram_dout
  );
endinterface

`default_nettype wire

// File: rtl/p_mem_ctrl.sv
// ============================================================================
// p_mem_ctrl : arbitrates IF fetches and MEM loads/stores onto a byte-wide RAM
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module p_mem_ctrl (
  input  logic         clk_in,
  input  logic         rst_in,
  p_mem_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_is_mem;
  logic [31:0] r_addr;
  logic [2:0]  r_n;
  logic        r_sext;
  logic [31:0] r_wdata;
  logic [2:0]  r_i;
  logic [2:0]  r_c;
  logic        r_inflight;
  logic [31:0] r_buf;
  logic [31:0] r_last_a;
  logic        r_if_done;
  logic        r_mem_done;
  logic [31:0] r_if_data;
  logic [31:0] r_mem_rdata;

  logic        w_issue_rd;
  logic        w_issue_wr;
  logic        w_issue;
  logic [31:0] w_issue_a;
  logic [7:0]  w_wbyte;
  logic        w_cap;
  logic [2:0]  w_c_after;
  logic [2:0]  w_req_n;
  logic [31:0] w_buf_next;
  logic [31:0] w_ext;

  assign w_issue_rd = (r_state == S_READ) && bus.rdy_in && (r_i < r_n);
  assign w_issue_wr = (r_state == S_WRITE) && bus.rdy_in;
  assign w_issue    = w_issue_rd || w_issue_wr;
  assign w_issue_a  = r_addr + {29'd0, r_i};

  // The RAM returns data one cycle after the address, so capture trails issue
  assign w_cap      = (r_state == S_READ) && r_inflight;
  assign w_c_after  = r_c + {2'd0, w_cap};

  assign w_req_n = (bus.mem_len == 2'd0) ? 3'd1 :
                   (bus.mem_len == 2'd1) ? 3'd2 : 3'd4;

  always_comb begin
    w_wbyte = r_wdata[7:0];
    case (r_i[1:0])
      2'd0:    w_wbyte = r_wdata[7:0];
      2'd1:    w_wbyte = r_wdata[15:8];
      2'd2:    w_wbyte = r_wdata[23:16];
      default: w_wbyte = r_wdata[31:24];
    endcase
  end

  always_comb begin
    w_buf_next = r_buf;
    if (w_cap) begin
      case (r_c[1:0])
        2'd0:    w_buf_next[7:0]   = bus.ram_din;
        2'd1:    w_buf_next[15:8]  = bus.ram_din;
        2'd2:    w_buf_next[23:16] = bus.ram_din;
        default: w_buf_next[31:24] = bus.ram_din;
      endcase
    end
  end

  always_comb begin
    w_ext = w_buf_next;
    case (r_n)
      3'd1:    w_ext = {{24{r_sext & w_buf_next[7]}},  w_buf_next[7:0]};
      3'd2:    w_ext = {{16{r_sext & w_buf_next[15]}}, w_buf_next[15:0]};
      default: w_ext = w_buf_next;
    endcase
  end

  assign bus.ram_a     = w_issue ? w_issue_a : r_last_a;
  assign bus.ram_wr    = w_issue_wr;
  assign bus.ram_dout  = w_issue_wr ? w_wbyte : 8'd0;
  assign bus.if_done   = r_if_done;
  assign bus.if_data   = r_if_data;
  assign bus.mem_done  = r_mem_done;
  assign bus.mem_rdata = r_mem_rdata;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state     <= S_IDLE;
      r_is_mem    <= 1'b0;
      r_addr      <= 32'd0;
      r_n         <= 3'd4;
      r_sext      <= 1'b0;
      r_wdata     <= 32'd0;
      r_i         <= 3'd0;
      r_c         <= 3'd0;
      r_inflight  <= 1'b0;
      r_buf       <= 32'd0;
      r_last_a    <= 32'd0;
      r_if_done   <= 1'b0;
      r_mem_done  <= 1'b0;
      r_if_data   <= 32'd0;
      r_mem_rdata <= 32'd0;
    end else begin
      r_if_done   <= 1'b0;
      r_mem_done  <= 1'b0;
      r_if_data   <= 32'd0;
      r_mem_rdata <= 32'd0;
      if (w_issue) r_last_a <= w_issue_a;

      case (r_state)
        S_IDLE: begin
          r_i        <= 3'd0;
          r_c        <= 3'd0;
          r_inflight <= 1'b0;
          r_buf      <= 32'd0;
          if (bus.mem_req) begin
            r_is_mem <= 1'b1;
            r_addr   <= bus.mem_addr;
            r_n      <= w_req_n;
            r_sext   <= bus.mem_sext & ~bus.mem_we;
            r_wdata  <= bus.mem_wdata;
            r_state  <= bus.mem_we ? S_WRITE : S_READ;
          end else if (bus.if_req) begin
            r_is_mem <= 1'b0;
            r_addr   <= bus.if_addr;
            r_n      <= 3'd4;
            r_sext   <= 1'b0;
            r_state  <= S_READ;
          end
        end

        S_READ: begin
          if (w_issue_rd) begin
            r_i        <= r_i + 3'd1;
            r_inflight <= 1'b1;
          end else begin
            r_inflight <= 1'b0;
          end
          if (w_cap) begin
            r_buf <= w_buf_next;
            r_c   <= w_c_after;
          end
          // A stalled cycle holds the state even when the last byte lands
          if (bus.rdy_in && (w_c_after == r_n)) begin
            r_state <= S_DONE;
            if (r_is_mem) begin
              r_mem_done  <= 1'b1;
              r_mem_rdata <= w_ext;
            end else begin
              r_if_done <= 1'b1;
              r_if_data <= w_buf_next;
            end
          end
        end

        S_WRITE: begin
          if (bus.rdy_in) begin
            r_i <= r_i + 3'd1;
            if (r_i == (r_n - 3'd1)) begin
              r_state    <= S_DONE;
              r_mem_done <= 1'b1;
            end
          end
        end

        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_p_mem_ctrl.sv
// ============================================================================
// tb_p_mem_ctrl : directed self-checking bench with a byte-wide RAM model
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_p_mem_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic preload = 1'b1;

  p_mem_ctrl_if bus();

  p_mem_ctrl dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [0:1023];

  // RAM model: registered read of the address presented in the current cycle
  always @(posedge clk) begin
    if (preload) begin
      for (int j = 0; j < 1024; j++) ram[j] = 8'h00;
      ram[10'h100] = 8'h13; ram[10'h101] = 8'h05;
      ram[10'h102] = 8'h00; ram[10'h103] = 8'h00;
      ram[10'h020] = 8'h80;
      ram[10'h043] = 8'h5A;
      ram[10'h200] = 8'h11; ram[10'h201] = 8'h22;
      ram[10'h202] = 8'h33; ram[10'h203] = 8'h44;
      ram[10'h3FF] = 8'h34; ram[10'h000] = 8'hF2;
    end else begin
      bus.ram_din <= ram[bus.ram_a[9:0]];
      if (bus.ram_wr) ram[bus.ram_a[9:0]] = bus.ram_dout;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic both_seen = 1'b0;
  int mem_done_cnt = 0;

  always @(negedge clk) begin
    if (bus.if_done && bus.mem_done) both_seen = 1'b1;
    if (bus.mem_done) mem_done_cnt++;
  end

  logic [31:0] a_log    [0:63];
  logic        wr_log   [0:63];
  logic [7:0]  dout_log [0:63];
  int          wr_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic mem_setup(input logic we, input logic [1:0] len, input logic sext,
                           input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    bus.mem_req   = 1'b1;
    bus.mem_we    = we;
    bus.mem_len   = len;
    bus.mem_sext  = sext;
    bus.mem_addr  = addr;
    bus.mem_wdata = wdata;
  endtask

  // Cycle k is the k-th cycle after the grant edge; rdy_in is low in cycles
  // stall_at .. stall_at+stall_len-1.
  task automatic run(input int budget, input int stall_at, input int stall_len,
                     output int if_cyc, output int mem_cyc,
                     output logic [31:0] if_d, output logic [31:0] mem_d);
    if_cyc = 0; mem_cyc = 0; if_d = 32'd0; mem_d = 32'd0; wr_cnt = 0;
    bus.rdy_in = !(1 >= stall_at && 1 < stall_at + stall_len);
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      a_log[k] = bus.ram_a; wr_log[k] = bus.ram_wr; dout_log[k] = bus.ram_dout;
      if (bus.ram_wr) wr_cnt++;
      if (bus.if_done && if_cyc == 0) begin
        if_cyc = k; if_d = bus.if_data; bus.if_req = 1'b0;
      end
      if (bus.mem_done && mem_cyc == 0) begin
        mem_cyc = k; mem_d = bus.mem_rdata; bus.mem_req = 1'b0;
      end
      bus.rdy_in = !((k + 1) >= stall_at && (k + 1) < stall_at + stall_len);
      if (!bus.if_req && !bus.mem_req) break;
    end
    if (bus.if_req || bus.mem_req) begin
      check("timeout", 32'd1, 32'd0);
      bus.if_req = 1'b0;
      bus.mem_req = 1'b0;
    end
    bus.rdy_in = 1'b1;
  endtask

  int          ic, mc, base_cnt;
  logic [31:0] id, md;

  initial begin
    bus.rdy_in = 1'b1; bus.if_req = 1'b1; bus.if_addr = 32'h100;
    bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_len = 2'd0;
    bus.mem_sext = 1'b0; bus.mem_addr = 32'd0; bus.mem_wdata = 32'd0;

    // Reset held two cycles with a pending fetch
    @(negedge clk);
    preload = 1'b0;
    check("rst_done", {30'd0, bus.if_done, bus.mem_done}, 32'd0);
    check("rst_if_data", bus.if_data, 32'd0);
    check("rst_mem_rdata", bus.mem_rdata, 32'd0);
    check("rst_ram_a", bus.ram_a, 32'd0);
    check("rst_ram_wr_dout", {23'd0, bus.ram_wr, bus.ram_dout}, 32'd0);
    @(negedge clk);
    check("rst2_done", {30'd0, bus.if_done, bus.mem_done}, 32'd0);
    rst = 1'b0;

    // Fetch granted at the edge after reset falls
    run(20, 0, 0, ic, mc, id, md);
    check("if_cycle", ic, 32'd6);
    check("if_data", id, 32'h00000513);
    for (int k = 1; k <= 4; k++) check("if_ram_a", a_log[k], 32'h100 + k - 1);

    mem_setup(1'b0, 2'd0, 1'b1, 32'h20, 32'd0);
    run(20, 0, 0, ic, mc, id, md);
    check("lb_cycle", mc, 32'd3);
    check("lb_data", md, 32'hFFFFFF80);

    mem_setup(1'b0, 2'd0, 1'b0, 32'h20, 32'd0);
    run(20, 0, 0, ic, mc, id, md);
    check("lbu_cycle", mc, 32'd3);
    check("lbu_data", md, 32'h00000080);

    mem_setup(1'b1, 2'd1, 1'b0, 32'h41, 32'hAABBCCDD);
    run(20, 0, 0, ic, mc, id, md);
    check("sh_cycle", mc, 32'd3);
    check("sh_rdata", md, 32'd0);
    check("sh_wr_cnt", wr_cnt, 32'd2);
    check("sh_a0", a_log[1], 32'h41);
    check("sh_d0", {24'd0, dout_log[1]}, 32'hDD);
    check("sh_a1", a_log[2], 32'h42);
    check("sh_d1", {24'd0, dout_log[2]}, 32'hCC);
    check("sh_ram41", {24'd0, ram[10'h041]}, 32'hDD);
    check("sh_ram43", {24'd0, ram[10'h043]}, 32'h5A);

    // Half load straddling the top of the address space
    mem_setup(1'b0, 2'd1, 1'b1, 32'hFFFFFFFF, 32'd0);
    run(20, 0, 0, ic, mc, id, md);
    check("wrap_cycle", mc, 32'd4);
    check("wrap_data", md, 32'hFFFFF234);
    check("wrap_a0", a_log[1], 32'hFFFFFFFF);
    check("wrap_a1", a_log[2], 32'h00000000);

    // Simultaneous requests: MEM first, IF granted from the next IDLE
    mem_setup(1'b0, 2'd2, 1'b0, 32'h200, 32'd0);
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    run(40, 0, 0, ic, mc, id, md);
    check("arb_mem_cycle", mc, 32'd6);
    check("arb_mem_data", md, 32'h44332211);
    check("arb_if_cycle", ic, 32'd13);
    check("arb_if_data", id, 32'h00000513);
    check("arb_both_done", {31'd0, both_seen}, 32'd0);

    // Three stalled cycles after the second issue
    mem_setup(1'b0, 2'd2, 1'b0, 32'h200, 32'd0);
    run(40, 3, 3, ic, mc, id, md);
    check("stall_cycle", mc, 32'd9);
    check("stall_data", md, 32'h44332211);

    // Reset in the middle of a word store
    mem_setup(1'b1, 2'd2, 1'b0, 32'h300, 32'h01020304);
    base_cnt = mem_done_cnt;
    @(negedge clk);
    @(negedge clk);
    check("abort_wr_before", {31'd0, bus.ram_wr}, 32'd1);
    rst = 1'b1;
    bus.mem_req = 1'b0;
    @(negedge clk);
    check("abort_wr_after", {31'd0, bus.ram_wr}, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_no_done", mem_done_cnt - base_cnt, 32'd0);
    check("abort_ram300", {24'd0, ram[10'h300]}, 32'h04);
    check("abort_ram301", {24'd0, ram[10'h301]}, 32'h03);
    check("abort_ram302", {24'd0, ram[10'h302]}, 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/p_mem_ctrl.md
# p_mem_ctrl

Memory controller and arbiter for the single byte-wide RAM port of the pipelined core. It shares that port between instruction fetch (IF, word reads) and the MEM stage (byte/half/word loads and stores), serialising each access into per-byte RAM cycles. Loads are sign- or zero-extended. One-cycle done pulses let each requester release its stall.

## Interface
- No parameters.
- clk_in  in  1  clock.
- rst_in  in  1  synchronous, active-high reset.
- rdy_in  in  1  global ready; low pauses byte issue.
- if_req  in  1  fetch request; held high until if_done.
- if_addr  in  32  fetch byte address; stable while if_req.
- if_done  out  1  one-cycle pulse; if_data valid in same cycle.
- if_data  out  32  fetched word, little-endian.
- mem_req  in  1  load/store request; held high until mem_done.
- mem_we  in  1  1 = store, 0 = load.
- mem_len  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
- mem_sext  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- mem_addr  in  32  byte address; no alignment required.
- mem_wdata  in  32  store data; low n bytes are used.
- mem_done  out  1  one-cycle completion pulse.
- mem_rdata  out  32  extended load data, valid with mem_done. Stores return 0.
- ram_a  out  32  RAM byte address.
- ram_wr  out  1  RAM write strobe.
- ram_dout  out  8  RAM write byte.
- ram_din  in  8  RAM read byte for the ram_a presented in the previous cycle.

## Operation
- Byte count n: 1, 2 or 4, set by mem_len. IF requests always use n = 4.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - mem_req has priority over if_req.
  - On the grant edge, latch requester id, address, n, we, sext and wdata.
  - Clear issue index i and capture index c.
  - Go to READ (load or fetch) or WRITE (store).
  - With no request, stay in IDLE.
- READ issue:
  - Each cycle with rdy_in = 1 and i < n: ram_a = addr + i, ram_wr = 0. At the edge, i increments and flag inflight is set.
  - Otherwise inflight is cleared.
- READ capture:
  - At every edge where inflight = 1, ram_din is stored into byte c and c increments.
  - Capture happens regardless of rdy_in.
  - When the capture makes c == n, go to DONE.
- WRITE:
  - Each cycle with rdy_in = 1: ram_a = addr + i, ram_dout = wdata byte i, ram_wr = 1. At the edge, i increments.
  - After the byte with i == n − 1 is written, go to DONE.
- DONE (exactly one cycle):
  - The granted requester's done is 1 and its data is valid. The other done stays 0.
  - Next state is IDLE. Requests are not sampled in DONE, so a request still high is not re-granted.
- Extension: byte n−1 bit 7 is replicated into bits 31..8n when mem_sext = 1; those bits are zero otherwise. Word loads are unextended.
- Addresses wrap modulo 2^32: 0xFFFFFFFF + 1 = 0.
- Idle values: when not issuing a write, ram_wr = 0 and ram_dout = 0. ram_a holds its last value. Data outputs are 0 outside DONE.
- IF and MEM are never granted in the same transaction. The loser keeps its request high and is granted from the next IDLE.

## Timing
- Reset: at the first edge with rst_in = 1, state ← IDLE and i, c, inflight ← 0. Outputs are then: if_done = 0, mem_done = 0, if_data = 0, mem_rdata = 0, ram_a = 0, ram_wr = 0, ram_dout = 0.
- Reset mid-transaction aborts it. No done pulse is produced, and partially written bytes stay written.
- Load / fetch latency with rdy_in held high:
  - grant edge E0, issues in cycles 1..n, captures at edges E2..E(n+1).
  - done is high in cycle n+2. A word therefore takes 6 cycles including the DONE cycle.
- Store latency with rdy_in held high:
  - writes in cycles 1..n, done in cycle n+1. A word store takes 5 cycles.
- rdy_in low:
  - No issue and no state advance; ram_wr = 0; i is held.
  - A byte already in flight is still captured.
  - Each low cycle adds exactly one cycle of latency.
- Back-to-back: a request held through DONE is granted at the IDLE edge that follows DONE.

## Test plan
- Reset: assert rst_in for 2 cycles with if_req = 1 -> all outputs 0. The first grant happens at the edge after rst_in falls.
- IF fetch: if_addr = 0x100, RAM[0x100..0x103] = 13 05 00 00 -> ram_a runs 0x100..0x103, if_done in cycle 6, if_data = 0x00000513.
- Signed and unsigned byte load: RAM[0x20] = 0x80.
  - mem_sext = 1 -> mem_rdata = 0xFFFFFF80.
  - mem_sext = 0 -> mem_rdata = 0x00000080.
  - mem_done in cycle 3 in both cases.
- Half store: mem_addr = 0x41 (misaligned), mem_wdata = 0xAABBCCDD -> ram_wr high for 2 cycles writing 0xDD@0x41 then 0xCC@0x42; mem_done in cycle 3.
- Contention: if_req and mem_req rise on the same edge -> the MEM word load completes first, then IF is granted at the next IDLE edge. No cycle has both done outputs high.
- Stall and reset:
  - rdy_in low for 3 cycles after the second issue of a word load -> correct word, done delayed by exactly 3 cycles.
  - rst_in during a WRITE -> ram_wr = 0 on the next cycle and no mem_done.
